reservation_station: RTL and testbench
======================================

Name: reservation_station

Overview:
Single-FU issue queue placed between dispatch and the FunctionalUnit.
- Buffers dispatched ALU ops until both operands are ready.
- Snoops the wakeup buses for producer tags and captures their values.
- Issues one ready op per cycle into the FU using its write_enable/is_available handshake.

Parameters:
- DEPTH, 8, number of entries (power of 2, ≥2)
- NUM_WAKEUP, 2, number of wakeup buses snooped
- TAG_W, 6, physical tag width
- ROB_W, 6, ROB index width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- flush  in  1  discard all entries (mispredict recovery)
- dispatch_valid  in  1  new op offered
- dispatch_ready  out  1  an entry is free
- dispatch_ALUControl  in  4  op code
- dispatch_ALUSrc  in  1  1 = use imm as RHS
- dispatch_is_for_lsq  in  1  result goes to LSQ address bus
- dispatch_imm  in  32  immediate
- dispatch_rs1_tag, dispatch_rs2_tag  in  TAG_W  source tags
- dispatch_rs1_ready, dispatch_rs2_ready  in  1  value already valid
- dispatch_rs1_value, dispatch_rs2_value  in  32  value when ready
- dispatch_tag_to_output  in  TAG_W  destination tag
- dispatch_rob_index  in  ROB_W  ROB slot
- wakeup_active  in  NUM_WAKEUP  per-bus broadcast valid
- wakeup_tag  in  NUM_WAKEUP*TAG_W  packed tags, bus i at [i*TAG_W +: TAG_W]
- wakeup_value  in  NUM_WAKEUP*32  packed values
- fu_is_available  in  1  FU can accept this cycle
- fu_write_enable  out  1  issue strobe
- fu_ALUControl  out  4
- fu_ALUSrc  out  1
- fu_is_for_lsq  out  1
- fu_imm, fu_rs1_value, fu_rs2_value  out  32
- fu_tag_to_output  out  TAG_W
- fu_rob_index  out  ROB_W
- occupancy  out  $clog2(DEPTH)+1  valid entry count

Behaviour:
- Reset (synchronous, active-high): all entries invalid. occupancy=0, dispatch_ready=1, fu_write_enable=0. fu_* payload outputs are 0.
- Per entry: valid, op fields, rs1/rs2 {ready, tag, value}.
- Dispatch: accepted when dispatch_valid && dispatch_ready. It is written into the lowest-index free entry at the clock edge.
- dispatch_ready = (occupancy < DEPTH), computed from registered state. A full queue reports not-ready even if an issue frees an entry in the same cycle.
- Dispatch-time bypass: a not-ready source whose tag matches an active wakeup bus in the same cycle is stored as ready, with that bus's value.
- Wakeup: every valid, not-ready source whose tag matches an active bus sets ready and latches the value. If several buses match, the lowest bus index wins (duplicate tags are illegal; the bench flags them).
- Readiness is registered: an entry woken at edge N is first issuable in cycle N+1.
- Select: among valid entries with both sources ready, pick the lowest index.
- Issue: fu_write_enable = a ready entry exists && fu_is_available && !flush. It is combinational from registered state.
  - fu_* carry the selected entry's payload; they are 0 when nothing is selected.
  - The issued entry is invalidated at the same edge.
- RHS choice (imm vs rs2) is the FU's job; the RS passes both values. When ALUSrc=1, rs2 is treated as ready at dispatch.
- Simultaneous dispatch and issue: allowed, into different entries. Occupancy is unchanged.
- Flush: all entries invalid next cycle, and any dispatch in that cycle is dropped. Flush has priority over dispatch, wakeup and issue.
- Reset mid-operation: same as flush; nothing is issued.
- Latency: a dispatched op with both sources ready issues at earliest the cycle after dispatch.
- Throughput: one issue per cycle while fu_is_available stays high.
- Invariant: occupancy equals popcount(valid). Dispatch while not ready is a fatal error.

Decomposition:
- Shared package holds:
  - ALUControl constants: NONE=0, OR=1, ADD=2, XOR=3, SRA=11, PASS_RHS=15.
  - TAG_W and ROB_W.
  - The packed entry struct/field widths.
- One sub-module, rs_select: parameterized lowest-index priority picker. It outputs a one-hot grant plus an any-bit and is used for both free-slot allocation and issue selection.

Test Plan:
- Reset, then dispatch ADD with rs1=5, rs2=7, both ready, fu_is_available=1 -> next cycle fu_write_enable=1, fu_rs1_value=5, fu_rs2_value=7, occupancy returns to 0.
- Dispatch OR with rs1 tag 9 not ready; drive wakeup bus1 tag 9 value 0xF0 two cycles later -> issue the cycle after wakeup with fu_rs1_value=0xF0, never earlier.
- Dispatch with rs2 tag 3 while bus0 broadcasts tag 3 value 0x1234 in the same cycle -> entry stored ready, issues next cycle with rs2=0x1234.
- Fill all 8 entries not-ready -> dispatch_ready=0 and occupancy=8. Wake entries 5 and 2 together -> entry 2 issues first, entry 5 next cycle, dispatch_ready=1 after the first issue edge.
- Hold fu_is_available=0 with 3 ready entries -> no issue, payload held. Raise it -> three consecutive issues in index order 0, 1, 2.
- With 4 entries valid, assert flush together with dispatch_valid -> occupancy=0 next cycle, no issue that cycle, the dispatched op is dropped.

Source files
------------

// File: rtl/reservation_station_pkg.sv
// reservation_station_pkg: shared widths, ALU opcodes and the per-entry op payload.
package reservation_station_pkg;
   localparam int RS_TAG_W = 6;
   localparam int RS_ROB_W = 6;
   localparam int ALU_W = 4;
   localparam int VAL_W = 32;
   localparam logic [ALU_W-1:0] ALU_NONE = 4'd0;
   localparam logic [ALU_W-1:0] ALU_OR = 4'd1;
   localparam logic [ALU_W-1:0] ALU_ADD = 4'd2;
   localparam logic [ALU_W-1:0] ALU_XOR = 4'd3;
   localparam logic [ALU_W-1:0] ALU_SRA = 4'd11;
   localparam logic [ALU_W-1:0] ALU_PASS_RHS = 4'd15;
   typedef struct packed {
      logic [ALU_W-1:0] alu_control;
      logic alu_src;
      logic is_for_lsq;
      logic [VAL_W-1:0] imm;
   } op_t;
endpackage

// File: rtl/rs_select.sv
// rs_select: lowest-index priority picker producing a one-hot grant and an any flag.
module rs_select #(
   parameter int N = 8
) (
   input logic [N-1:0] req,
   output logic [N-1:0] grant,
   output logic any
);
   assign grant = req & (~req + N'(1));
   assign any = |req;
endmodule

// File: rtl/reservation_station.sv
// reservation_station: single-FU issue queue that wakes sources off the broadcast buses
// and issues the lowest-index ready op into the FU.
module reservation_station
   import reservation_station_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int NUM_WAKEUP = 2,
   parameter int TAG_W = RS_TAG_W,
   parameter int ROB_W = RS_ROB_W,
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input logic clk,
   input logic reset,
   input logic flush,
   input logic dispatch_valid,
   output logic dispatch_ready,
   input logic [ALU_W-1:0] dispatch_ALUControl,
   input logic dispatch_ALUSrc,
   input logic dispatch_is_for_lsq,
   input logic [VAL_W-1:0] dispatch_imm,
   input logic [TAG_W-1:0] dispatch_rs1_tag,
   input logic [TAG_W-1:0] dispatch_rs2_tag,
   input logic dispatch_rs1_ready,
   input logic dispatch_rs2_ready,
   input logic [VAL_W-1:0] dispatch_rs1_value,
   input logic [VAL_W-1:0] dispatch_rs2_value,
   input logic [TAG_W-1:0] dispatch_tag_to_output,
   input logic [ROB_W-1:0] dispatch_rob_index,
   input logic [NUM_WAKEUP-1:0] wakeup_active,
   input logic [NUM_WAKEUP*TAG_W-1:0] wakeup_tag,
   input logic [NUM_WAKEUP*VAL_W-1:0] wakeup_value,
   input logic fu_is_available,
   output logic fu_write_enable,
   output logic [ALU_W-1:0] fu_ALUControl,
   output logic fu_ALUSrc,
   output logic fu_is_for_lsq,
   output logic [VAL_W-1:0] fu_imm,
   output logic [VAL_W-1:0] fu_rs1_value,
   output logic [VAL_W-1:0] fu_rs2_value,
   output logic [TAG_W-1:0] fu_tag_to_output,
   output logic [ROB_W-1:0] fu_rob_index,
   output logic [CNT_W-1:0] occupancy
);
   logic [DEPTH-1:0] valid, rs1_rdy, rs2_rdy, alloc, issue;
   op_t op [DEPTH];
   logic [TAG_W-1:0] rs1_tag [DEPTH], rs2_tag [DEPTH], dst_tag [DEPTH];
   logic [ROB_W-1:0] rob [DEPTH];
   logic [VAL_W-1:0] rs1_val [DEPTH], rs2_val [DEPTH];
   logic [VAL_W:0] w1 [DEPTH], w2 [DEPTH];
   logic [VAL_W:0] dw1, dw2;
   logic [CNT_W-1:0] count;
   logic free_any, issue_any, accept;

   // {hit, value} for a tag; iterating downward lets the lowest matching bus win
   function automatic logic [VAL_W:0] snoop(input logic [TAG_W-1:0] t);
      snoop = '0;
      for (int i = NUM_WAKEUP - 1; i >= 0; i--)
         if (wakeup_active[i] && wakeup_tag[i*TAG_W +: TAG_W] == t)
            snoop = {1'b1, wakeup_value[i*VAL_W +: VAL_W]};
   endfunction

   rs_select #(.N(DEPTH)) u_alloc (.req(~valid), .grant(alloc), .any(free_any));
   rs_select #(.N(DEPTH)) u_issue (.req(valid & rs1_rdy & rs2_rdy), .grant(issue), .any(issue_any));

   assign occupancy = count;
   assign dispatch_ready = count < CNT_W'(DEPTH);
   assign accept = dispatch_valid && dispatch_ready && free_any && !flush;
   assign fu_write_enable = issue_any && fu_is_available && !flush && !reset;

   always_comb begin
      dw1 = snoop(dispatch_rs1_tag);
      dw2 = snoop(dispatch_rs2_tag);
      for (int i = 0; i < DEPTH; i++) begin
         w1[i] = snoop(rs1_tag[i]);
         w2[i] = snoop(rs2_tag[i]);
      end
   end

   always_comb begin
      fu_ALUControl = '0;
      fu_ALUSrc = 1'b0;
      fu_is_for_lsq = 1'b0;
      fu_imm = '0;
      fu_rs1_value = '0;
      fu_rs2_value = '0;
      fu_tag_to_output = '0;
      fu_rob_index = '0;
      for (int i = 0; i < DEPTH; i++)
         if (issue[i]) begin
            fu_ALUControl = op[i].alu_control;
            fu_ALUSrc = op[i].alu_src;
            fu_is_for_lsq = op[i].is_for_lsq;
            fu_imm = op[i].imm;
            fu_rs1_value = rs1_val[i];
            fu_rs2_value = rs2_val[i];
            fu_tag_to_output = dst_tag[i];
            fu_rob_index = rob[i];
         end
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         valid <= '0;
         count <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && !rs1_rdy[i] && w1[i][VAL_W]) begin
               rs1_rdy[i] <= 1'b1;
               rs1_val[i] <= w1[i][VAL_W-1:0];
            end
            if (valid[i] && !rs2_rdy[i] && w2[i][VAL_W]) begin
               rs2_rdy[i] <= 1'b1;
               rs2_val[i] <= w2[i][VAL_W-1:0];
            end
            if (fu_write_enable && issue[i])
               valid[i] <= 1'b0;
            if (accept && alloc[i]) begin
               valid[i] <= 1'b1;
               op[i] <= {dispatch_ALUControl, dispatch_ALUSrc, dispatch_is_for_lsq, dispatch_imm};
               rs1_tag[i] <= dispatch_rs1_tag;
               rs2_tag[i] <= dispatch_rs2_tag;
               dst_tag[i] <= dispatch_tag_to_output;
               rob[i] <= dispatch_rob_index;
               rs1_rdy[i] <= dispatch_rs1_ready || dw1[VAL_W];
               rs1_val[i] <= dispatch_rs1_ready ? dispatch_rs1_value : dw1[VAL_W-1:0];
               // an immediate-RHS op never waits on rs2
               rs2_rdy[i] <= dispatch_ALUSrc || dispatch_rs2_ready || dw2[VAL_W];
               rs2_val[i] <= dispatch_rs2_ready || !dw2[VAL_W] ? dispatch_rs2_value : dw2[VAL_W-1:0];
            end
         end
         count <= count + CNT_W'(accept) - CNT_W'(fu_write_enable);
      end
   end
endmodule

// File: tb/tb_reservation_station.sv
// tb_reservation_station: directed scenarios plus randomized traffic checked every cycle
// against an entry-array reference model.
module tb_reservation_station;
   import reservation_station_pkg::*;
   localparam int DEPTH = 8;
   localparam int NW = 2;
   localparam int TW = 6;
   localparam int RW = 6;
   localparam int CW = 4;

   logic clk = 1'b0;
   logic reset, flush, dispatch_valid, dispatch_ready, dispatch_ALUSrc, dispatch_is_for_lsq;
   logic [3:0] dispatch_ALUControl;
   logic [31:0] dispatch_imm, dispatch_rs1_value, dispatch_rs2_value;
   logic [TW-1:0] dispatch_rs1_tag, dispatch_rs2_tag, dispatch_tag_to_output;
   logic dispatch_rs1_ready, dispatch_rs2_ready;
   logic [RW-1:0] dispatch_rob_index;
   logic [NW-1:0] wakeup_active;
   logic [NW*TW-1:0] wakeup_tag;
   logic [NW*32-1:0] wakeup_value;
   logic fu_is_available, fu_write_enable, fu_ALUSrc, fu_is_for_lsq;
   logic [3:0] fu_ALUControl;
   logic [31:0] fu_imm, fu_rs1_value, fu_rs2_value;
   logic [TW-1:0] fu_tag_to_output;
   logic [RW-1:0] fu_rob_index;
   logic [CW-1:0] occupancy;

   always #5 clk = ~clk;

   reservation_station #(.DEPTH(DEPTH), .NUM_WAKEUP(NW), .TAG_W(TW), .ROB_W(RW)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
      .dispatch_ALUControl(dispatch_ALUControl), .dispatch_ALUSrc(dispatch_ALUSrc),
      .dispatch_is_for_lsq(dispatch_is_for_lsq), .dispatch_imm(dispatch_imm),
      .dispatch_rs1_tag(dispatch_rs1_tag), .dispatch_rs2_tag(dispatch_rs2_tag),
      .dispatch_rs1_ready(dispatch_rs1_ready), .dispatch_rs2_ready(dispatch_rs2_ready),
      .dispatch_rs1_value(dispatch_rs1_value), .dispatch_rs2_value(dispatch_rs2_value),
      .dispatch_tag_to_output(dispatch_tag_to_output), .dispatch_rob_index(dispatch_rob_index),
      .wakeup_active(wakeup_active), .wakeup_tag(wakeup_tag), .wakeup_value(wakeup_value),
      .fu_is_available(fu_is_available), .fu_write_enable(fu_write_enable),
      .fu_ALUControl(fu_ALUControl), .fu_ALUSrc(fu_ALUSrc), .fu_is_for_lsq(fu_is_for_lsq),
      .fu_imm(fu_imm), .fu_rs1_value(fu_rs1_value), .fu_rs2_value(fu_rs2_value),
      .fu_tag_to_output(fu_tag_to_output), .fu_rob_index(fu_rob_index), .occupancy(occupancy)
   );

   typedef struct packed {
      logic v;
      logic [3:0] alu;
      logic src, lsq;
      logic [31:0] imm;
      logic r1;
      logic [TW-1:0] t1;
      logic [31:0] v1;
      logic r2;
      logic [TW-1:0] t2;
      logic [31:0] v2;
      logic [TW-1:0] dst;
      logic [RW-1:0] rob;
   } ent_t;

   ent_t m [DEPTH];
   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // first active bus carrying the tag supplies the value
   function automatic logic [32:0] snoop(input logic [TW-1:0] t);
      for (int b = 0; b < NW; b++)
         if (wakeup_active[b] && wakeup_tag[b*TW +: TW] == t) return {1'b1, wakeup_value[b*32 +: 32]};
      return '0;
   endfunction

   function automatic int m_occ();
      int n = 0;
      foreach (m[i]) n += int'(m[i].v);
      return n;
   endfunction

   // compare this cycle's outputs, then advance the model across the coming edge
   task automatic cyc();
      int sel, occ, fr;
      ent_t e;
      logic we;
      logic [32:0] h;
      #2;
      sel = -1;
      fr = -1;
      occ = m_occ();
      foreach (m[i]) begin
         if (sel < 0 && m[i].v && m[i].r1 && m[i].r2) sel = i;
         if (fr < 0 && !m[i].v) fr = i;
      end
      e = sel >= 0 ? m[sel] : '0;
      we = sel >= 0 && fu_is_available && !flush && !reset;
      check("issue", fu_write_enable, we);
      check("occupancy", occupancy, occ);
      check("dispatch_ready", dispatch_ready, occ < DEPTH);
      check("ctl", {fu_ALUControl, fu_ALUSrc, fu_is_for_lsq}, {e.alu, e.src, e.lsq});
      check("imm", fu_imm, e.imm);
      check("rs1", fu_rs1_value, e.v1);
      check("rs2", fu_rs2_value, e.v2);
      check("dst", fu_tag_to_output, e.dst);
      check("rob", fu_rob_index, e.rob);
      check("wakeup_dup", wakeup_active == 2'b11 && wakeup_tag[TW-1:0] == wakeup_tag[2*TW-1:TW], 0);
      check("dispatch_full", dispatch_valid && occ >= DEPTH, 0);
      if (reset || flush) begin
         foreach (m[i]) m[i].v = 1'b0;
      end else begin
         foreach (m[i])
            if (m[i].v) begin
               if (!m[i].r1) begin
                  h = snoop(m[i].t1);
                  if (h[32]) {m[i].r1, m[i].v1} = h;
               end
               if (!m[i].r2) begin
                  h = snoop(m[i].t2);
                  if (h[32]) {m[i].r2, m[i].v2} = h;
               end
            end
         if (we) m[sel].v = 1'b0;
         if (dispatch_valid && occ < DEPTH) begin
            e.v = 1'b1;
            e.alu = dispatch_ALUControl;
            e.src = dispatch_ALUSrc;
            e.lsq = dispatch_is_for_lsq;
            e.imm = dispatch_imm;
            e.t1 = dispatch_rs1_tag;
            e.t2 = dispatch_rs2_tag;
            e.dst = dispatch_tag_to_output;
            e.rob = dispatch_rob_index;
            h = snoop(dispatch_rs1_tag);
            e.r1 = dispatch_rs1_ready | h[32];
            e.v1 = dispatch_rs1_ready ? dispatch_rs1_value : h[31:0];
            h = snoop(dispatch_rs2_tag);
            e.r2 = dispatch_rs2_ready | h[32] | dispatch_ALUSrc;
            e.v2 = (dispatch_rs2_ready || !h[32]) ? dispatch_rs2_value : h[31:0];
            m[fr] = e;
         end
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      reset = 1'b0;
      flush = 1'b0;
      dispatch_valid = 1'b0;
      wakeup_active = '0;
   endtask

   task automatic disp(input logic [3:0] alu, input logic src, input logic [TW-1:0] t1, input logic r1,
                       input logic [31:0] v1, input logic [TW-1:0] t2, input logic r2,
                       input logic [31:0] v2, input logic [TW-1:0] dst);
      dispatch_valid = 1'b1;
      dispatch_ALUControl = alu;
      dispatch_ALUSrc = src;
      dispatch_is_for_lsq = dst[0];
      dispatch_imm = 32'h100 + 32'(dst);
      dispatch_rs1_tag = t1;
      dispatch_rs1_ready = r1;
      dispatch_rs1_value = v1;
      dispatch_rs2_tag = t2;
      dispatch_rs2_ready = r2;
      dispatch_rs2_value = v2;
      dispatch_tag_to_output = dst;
      dispatch_rob_index = dst + 6'd1;
   endtask

   task automatic wake(input int b, input logic [TW-1:0] t, input logic [31:0] v);
      wakeup_active[b] = 1'b1;
      wakeup_tag[b*TW +: TW] = t;
      wakeup_value[b*32 +: 32] = v;
   endtask

   initial begin
      logic [3:0] ops [6];
      ops = '{ALU_NONE, ALU_OR, ALU_ADD, ALU_XOR, ALU_SRA, ALU_PASS_RHS};
      idle();
      reset = 1'b1;
      fu_is_available = 1'b1;
      wakeup_tag = '0;
      wakeup_value = '0;
      disp(ALU_NONE, 0, 0, 0, 0, 0, 0, 0, 0);
      dispatch_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      foreach (m[i]) m[i] = '0;
      cyc();
      check("rst_occ", occupancy, 0);
      check("rst_ready", dispatch_ready, 1);
      check("rst_we", fu_write_enable, 0);
      check("rst_payload", {fu_imm, fu_rs1_value}, 0);
      nxt();

      // both sources ready: issue the next cycle
      idle();
      disp(ALU_ADD, 0, 6'd1, 1, 32'd5, 6'd2, 1, 32'd7, 6'd10);
      cyc(); check("s1_no_same_cycle", fu_write_enable, 0); nxt();
      idle();
      cyc(); check("s1_we", fu_write_enable, 1); check("s1_rs1", fu_rs1_value, 5); check("s1_rs2", fu_rs2_value, 7); nxt();
      cyc(); check("s1_occ", occupancy, 0); nxt();

      // wakeup on bus1 two cycles after dispatch
      disp(ALU_OR, 0, 6'd9, 0, 32'd0, 6'd4, 1, 32'd3, 6'd11);
      cyc(); nxt();
      idle();
      cyc(); check("s2_wait", fu_write_enable, 0); nxt();
      wake(1, 6'd9, 32'hF0);
      cyc(); check("s2_early", fu_write_enable, 0); nxt();
      idle();
      cyc(); check("s2_we", fu_write_enable, 1); check("s2_rs1", fu_rs1_value, 32'hF0); nxt();

      // dispatch-time bypass from bus0
      disp(ALU_XOR, 0, 6'd5, 1, 32'd1, 6'd3, 0, 32'd0, 6'd12);
      wake(0, 6'd3, 32'h1234);
      cyc(); nxt();
      idle();
      cyc(); check("s3_we", fu_write_enable, 1); check("s3_rs2", fu_rs2_value, 32'h1234); nxt();

      // fill, then wake entries 5 and 2 together
      for (int i = 0; i < DEPTH; i++) begin
         disp(ALU_ADD, 0, 6'(20 + i), 0, 0, 6'd1, 1, 32'(i), 6'(40 + i));
         cyc(); nxt();
      end
      idle();
      cyc(); check("s4_full_occ", occupancy, 8); check("s4_full_ready", dispatch_ready, 0); nxt();
      wake(0, 6'd25, 32'h55);
      wake(1, 6'd22, 32'h22);
      cyc(); nxt();
      idle();
      cyc(); check("s4_first", fu_tag_to_output, 42); check("s4_still_full", dispatch_ready, 0); nxt();
      cyc(); check("s4_second", fu_tag_to_output, 45); check("s4_freed", dispatch_ready, 1); nxt();
      flush = 1'b1;
      cyc(); nxt();
      idle();
      cyc(); check("s4_flushed", occupancy, 0); nxt();

      // stalled FU holds the payload, then drains in index order
      fu_is_available = 1'b0;
      for (int i = 0; i < 3; i++) begin
         disp(ALU_SRA, 1, 6'd30, 1, 32'(i), 6'd31, 0, 0, 6'(50 + i));
         cyc(); nxt();
      end
      idle();
      repeat (2) begin
         cyc(); check("s5_stall", fu_write_enable, 0); check("s5_hold", fu_tag_to_output, 50); nxt();
      end
      fu_is_available = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc(); check("s5_drain_we", fu_write_enable, 1); check("s5_drain_dst", fu_tag_to_output, 50 + i); nxt();
      end

      // flush beats a same-cycle dispatch
      for (int i = 0; i < 4; i++) begin
         disp(ALU_OR, 0, 6'd60, 0, 0, 6'd61, 0, 0, 6'(i));
         cyc(); nxt();
      end
      disp(ALU_ADD, 0, 6'd1, 1, 32'd1, 6'd2, 1, 32'd2, 6'd33);
      flush = 1'b1;
      cyc(); check("s6_flush_we", fu_write_enable, 0); nxt();
      idle();
      cyc(); check("s6_occ", occupancy, 0); check("s6_dropped", fu_write_enable, 0); nxt();

      for (int k = 0; k < 3000; k++) begin
         idle();
         reset = $urandom_range(0, 255) == 0;
         flush = $urandom_range(0, 47) == 0;
         fu_is_available = $urandom_range(0, 3) != 0;
         wakeup_active = NW'($urandom);
         wakeup_tag = {6'($urandom_range(0, 7)), 6'($urandom_range(0, 7))};
         wakeup_value = {$urandom, $urandom};
         if (wakeup_active == 2'b11 && wakeup_tag[TW-1:0] == wakeup_tag[2*TW-1:TW])
            wakeup_tag[2*TW-1:TW] = wakeup_tag[TW-1:0] ^ 6'd1;
         if (m_occ() < DEPTH && $urandom_range(0, 2) != 0)
            disp(ops[$urandom_range(0, 5)], 1'($urandom), 6'($urandom_range(0, 7)), 1'($urandom_range(0, 2) == 0),
                 $urandom, 6'($urandom_range(0, 7)), 1'($urandom_range(0, 2) == 0), $urandom, 6'($urandom));
         cyc();
         nxt();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
